// File: rtl/fpga_io_pkg.sv
// ---------------------------------------------------------------------------
// fpga_io_pkg
// Shared definitions for the FPGA IO driver and the logic that owns its
// addr/din/read_en port.
//   io_arb_state_t : state encoding of the write arbiter FSM
//   IO_ADDR_*      : driver-relative register addresses (seven-segment
//                    digits SS0..SS7, LEFT/RIGHT, push buttons)
// ---------------------------------------------------------------------------
package fpga_io_pkg;

    typedef enum logic [1:0] {
        IO_ARB_IDLE  = 2'd0,
        IO_ARB_ISSUE = 2'd1,
        IO_ARB_DONE  = 2'd2
    } io_arb_state_t;

    localparam logic [7:0] IO_ADDR_SS0   = 8'h00;
    localparam logic [7:0] IO_ADDR_SS1   = 8'h01;
    localparam logic [7:0] IO_ADDR_SS2   = 8'h02;
    localparam logic [7:0] IO_ADDR_SS3   = 8'h03;
    localparam logic [7:0] IO_ADDR_SS4   = 8'h04;
    localparam logic [7:0] IO_ADDR_SS5   = 8'h05;
    localparam logic [7:0] IO_ADDR_SS6   = 8'h06;
    localparam logic [7:0] IO_ADDR_SS7   = 8'h07;
    localparam logic [7:0] IO_ADDR_LEFT  = 8'h08;
    localparam logic [7:0] IO_ADDR_RIGHT = 8'h09;
    localparam logic [7:0] IO_ADDR_PB    = 8'h0A;

endpackage

// File: rtl/io_starve_counter.sv
// ---------------------------------------------------------------------------
// io_starve_counter
// Counts consecutive cycles on which the sequencer wanted the IO port but
// was denied. Saturates at LIMIT; at_limit tells the arbiter to force the
// next slot to the sequencer.
//   clk      : clock, rising edge
//   nrst     : asynchronous active-low reset
//   inc      : sequencer denied this cycle
//   clr      : sequencer wrote this cycle, or no sequence in progress
//   at_limit : count has reached LIMIT
// ---------------------------------------------------------------------------
module io_starve_counter #(
    parameter int LIMIT = 8,
    localparam int CW   = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic nrst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CW-1:0] count;

    assign at_limit = (count == CW'(LIMIT));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_io_write_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_io_write_arbiter
// Owns the single addr/din/read_en port of the FPGA IO driver and shares it
// between the CPU bus (priority) and a hex-display sequencer. The sequencer
// writes a DIGITS*4-bit value one nibble per cycle, highest nibble first,
// into SS_BASE+DIGITS-1 .. SS_BASE. A starvation counter forces a sequencer
// slot after STARVE_LIMIT consecutive denials.
//   clk, nrst                    : clock / asynchronous active-low reset
//   cpu_sel, cpu_read_en,
//   cpu_addr, cpu_din            : CPU access to the IO page
//   cpu_stall                    : sequencer took the port from the CPU
//   hex_valid, hex_ready,
//   hex_value                    : display request handshake
//   hex_done                     : one-cycle pulse after the last nibble
//   io_read_en, io_addr, io_din  : to the IO driver
//
// Handshake: a request transfers on a rising edge where hex_valid and
// hex_ready are both high. hex_ready depends only on arbiter state (never on
// hex_valid or cpu_sel); hex_valid is ignored while hex_ready is low.
// ---------------------------------------------------------------------------
module fpga_io_write_arbiter
    import fpga_io_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SS_BASE      = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cpu_sel,
    input  logic                  cpu_read_en,
    input  logic [7:0]            cpu_addr,
    input  logic [7:0]            cpu_din,
    output logic                  cpu_stall,
    input  logic                  hex_valid,
    output logic                  hex_ready,
    input  logic [DIGITS*4-1:0]   hex_value,
    output logic                  hex_done,
    output logic                  io_read_en,
    output logic [7:0]            io_addr,
    output logic [7:0]            io_din
);

    localparam int         IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SS_BASE_ADR = 8'(SS_BASE);

    io_arb_state_t        state;
    logic [IW-1:0]        index;
    logic [DIGITS*4-1:0]  value;
    logic                 ready_r;
    logic                 done_r;

    logic                 in_issue;
    logic                 starved;
    logic                 seq_grant;
    logic [3:0]           nibble;

    assign in_issue  = (state == IO_ARB_ISSUE);
    // CPU has priority unless the sequencer has waited STARVE_LIMIT cycles.
    assign seq_grant = in_issue && (!cpu_sel || starved);
    assign nibble    = value[{index, 2'b00} +: 4];

    assign hex_ready = ready_r;
    assign hex_done  = done_r;
    // Stall only on forced slots, i.e. when the CPU actually lost the port.
    assign cpu_stall = seq_grant && cpu_sel;

    io_starve_counter #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .nrst     (nrst),
        .inc      (in_issue && !seq_grant),
        .clr      (!in_issue || seq_grant),
        .at_limit (starved)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IO_ARB_IDLE;
            index   <= '0;
            value   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IO_ARB_IDLE: begin
                    if (hex_valid) begin
                        value   <= hex_value;
                        index   <= IW'(DIGITS - 1);
                        ready_r <= 1'b0;
                        state   <= IO_ARB_ISSUE;
                    end
                end
                IO_ARB_ISSUE: begin
                    if (seq_grant) begin
                        if (index == '0) begin
                            done_r <= 1'b1;
                            state  <= IO_ARB_DONE;
                        end else begin
                            index <= index - 1'b1;
                        end
                    end
                end
                IO_ARB_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IO_ARB_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IO_ARB_IDLE;
                end
            endcase
        end
    end

    // Port mux: sequencer write, else CPU pass-through, else idle value.
    always_comb begin
        io_read_en = 1'b1;
        io_addr    = 8'h00;
        io_din     = 8'h00;
        if (seq_grant) begin
            io_read_en = 1'b0;
            io_addr    = SS_BASE_ADR + {{(8-IW){1'b0}}, index};
            io_din     = {4'b0000, nibble};
        end else if (cpu_sel) begin
            io_read_en = cpu_read_en;
            io_addr    = cpu_addr;
            io_din     = cpu_din;
        end
    end

endmodule

// File: tb/tb_fpga_io_write_arbiter.sv
module tb_fpga_io_write_arbiter;

    localparam int DIGITS       = 4;
    localparam int SS_BASE      = 0;
    localparam int STARVE_LIMIT = 8;
    localparam int W            = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic                cpu_sel, cpu_read_en;
    logic [7:0]          cpu_addr, cpu_din;
    logic                cpu_stall;
    logic                hex_valid, hex_ready, hex_done;
    logic [DIGITS*4-1:0] hex_value;
    logic                io_read_en;
    logic [7:0]          io_addr, io_din;

    fpga_io_write_arbiter #(
        .DIGITS       (DIGITS),
        .SS_BASE      (SS_BASE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cpu_sel     (cpu_sel),
        .cpu_read_en (cpu_read_en),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_stall   (cpu_stall),
        .hex_valid   (hex_valid),
        .hex_ready   (hex_ready),
        .hex_value   (hex_value),
        .hex_done    (hex_done),
        .io_read_en  (io_read_en),
        .io_addr     (io_addr),
        .io_din      (io_din)
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds the display writes still owed, as {addr, data}, in order.
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int  denied   = 0;      // consecutive cycles the sequencer was refused
    bit  done_due = 0;      // a hex_done pulse is owed this cycle
    bit  saw_done = 0;
    int  stall_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit         grant;
        logic       e_re, e_st, e_rdy, e_dn;
        logic [7:0] e_a, e_d;
        grant = 0;
        e_rdy = 0;
        e_dn  = 0;
        if (exp_q.size() > 0)
            grant = !cpu_sel || (denied >= STARVE_LIMIT);
        else begin
            e_rdy = !done_due;
            e_dn  = done_due;
        end
        if (grant) begin
            e_re = 1'b0;
            e_a  = exp_q[0][15:8];
            e_d  = exp_q[0][7:0];
        end else if (cpu_sel) begin
            e_re = cpu_read_en;
            e_a  = cpu_addr;
            e_d  = cpu_din;
        end else begin
            e_re = 1'b1;
            e_a  = 8'h00;
            e_d  = 8'h00;
        end
        e_st = grant && cpu_sel;
        chk("io_read_en", 32'(io_read_en), 32'(e_re));
        chk("io_addr",    32'(io_addr),    32'(e_a));
        chk("io_din",     32'(io_din),     32'(e_d));
        chk("cpu_stall",  32'(cpu_stall),  32'(e_st));
        chk("hex_ready",  32'(hex_ready),  32'(e_rdy));
        chk("hex_done",   32'(hex_done),   32'(e_dn));
        saw_done = hex_done;
        if (cpu_stall) stall_seen++;
    endtask

    task automatic model_update();
        if (exp_q.size() > 0) begin
            if (!cpu_sel || denied >= STARVE_LIMIT) begin
                void'(exp_q.pop_front());
                denied = 0;
                if (exp_q.size() == 0) done_due = 1;
            end else begin
                denied++;
            end
        end else if (done_due) begin
            done_due = 0;
        end else if (hex_valid) begin
            for (int i = DIGITS - 1; i >= 0; i--)
                exp_q.push_back({8'(SS_BASE + i), 4'h0, hex_value[4*i +: 4]});
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        denied   = 0;
        done_due = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cpu_idle();
        cpu_sel     = 1'b0;
        cpu_read_en = 1'b1;
        cpu_addr    = 8'h00;
        cpu_din     = 8'h00;
    endtask

    task automatic cpu_rand();
        cpu_read_en = 1'($urandom_range(0, 1));
        cpu_addr    = 8'($urandom_range(0, 255));
        cpu_din     = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(hex_ready),  32'd1);
        chk({tag, "_done"},  32'(hex_done),   32'd0);
        chk({tag, "_stall"}, 32'(cpu_stall),  32'd0);
        chk({tag, "_re"},    32'(io_read_en), 32'd1);
        chk({tag, "_addr"},  32'(io_addr),    32'd0);
        chk({tag, "_din"},   32'(io_din),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] beef_d[4];
        int n;
        beef_d = '{8'h0B, 8'h0E, 8'h0E, 8'h0F};

        nrst      = 1'b0;
        hex_valid = 1'b0;
        hex_value = '0;
        cpu_idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        nrst = 1'b1;
        model_reset();
        cycle();

        // Uncontested 16'hBEEF: nibbles 3..0 on consecutive cycles.
        hex_valid = 1'b1;
        hex_value = 16'hBEEF;
        cycle();
        hex_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("beef_addr", 32'(io_addr), 32'(3 - k));
            chk("beef_din",  32'(io_din),  32'(beef_d[k]));
            cycle();
        end
        chk("beef_done",  32'(hex_done),  32'd1);
        cycle();
        chk("beef_ready", 32'(hex_ready), 32'd1);

        // CPU write in IDLE passes straight through.
        cpu_sel = 1'b1; cpu_read_en = 1'b0; cpu_addr = 8'h08; cpu_din = 8'h5A;
        #1;
        chk("cpu_pass_addr",  32'(io_addr),    32'h08);
        chk("cpu_pass_din",   32'(io_din),     32'h5A);
        chk("cpu_pass_re",    32'(io_read_en), 32'd0);
        chk("cpu_pass_stall", 32'(cpu_stall),  32'd0);
        cycle();
        cycle();

        // CPU saturation: 9 cycles per nibble, done on cycle 37 after accept.
        hex_valid = 1'b1;
        hex_value = 16'($urandom);
        cpu_sel   = 1'b1;
        cpu_rand();
        cycle();
        hex_valid = 1'b0;
        stall_seen = 0;
        n = 0;
        saw_done = 0;
        while (!saw_done && n < 100) begin
            cpu_rand();
            cycle();
            n++;
        end
        chk("sat_len",    32'(n),          32'(DIGITS * (STARVE_LIMIT + 1) + 1));
        chk("sat_stalls", 32'(stall_seen), 32'(DIGITS));
        cpu_idle();
        cycle();

        // Alternating cpu_sel, with a 16'h1234 request pulsed mid-sequence.
        hex_valid = 1'b1;
        hex_value = 16'hA5C3;
        cycle();
        hex_valid = 1'b0;
        stall_seen = 0;
        for (int k = 0; k < 10; k++) begin
            cpu_sel = (k % 2 == 0);
            cpu_rand();
            if (k == 3) begin
                hex_valid = 1'b1;
                hex_value = 16'h1234;
            end else begin
                hex_valid = 1'b0;
            end
            cycle();
        end
        chk("alt_no_stall", 32'(stall_seen), 32'd0);
        cpu_idle();
        hex_valid = 1'b0;
        repeat (3) cycle();

        // Reset after the second write aborts the sequence.
        hex_valid = 1'b1;
        hex_value = 16'h9876;
        cycle();
        hex_valid = 1'b0;
        cycle();
        cycle();
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        hex_valid = 1'b1;
        hex_value = 16'h4321;
        cycle();
        hex_valid = 1'b0;
        chk("restart_addr", 32'(io_addr), 32'(SS_BASE + DIGITS - 1));
        chk("restart_din",  32'(io_din),  32'h04);
        repeat (6) cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cpu_sel   = ($urandom_range(0, 99) < 70);
            cpu_rand();
            hex_valid = 1'($urandom_range(0, 1));
            hex_value = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
